// File: rtl/tx_cnt_pkg.sv
// Shared types, default frame-size constants and helpers for the TX frame byte counter.
package tx_cnt_pkg;

  // Counter FSM: waiting for a start of frame, or accumulating a frame.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  // Ethernet frame-size limits, not counting the FCS.
  localparam int ETH_MIN_LEN = 60;
  localparam int ETH_MAX_LEN = 1514;

  // Caps a per-beat byte count at the datapath width. Oversized values are
  // treated as a full beat and are not an error.
  function automatic int unsigned clamp_bytes(input int unsigned bytes,
                                              input int unsigned lanes);
    return (bytes > lanes) ? lanes : bytes;
  endfunction

endpackage

// File: rtl/tx_frame_byte_counter_sat_add.sv
// Combinational saturating adder: running count plus one beat's byte count.
module sat_add #(
  parameter int CNT_W  = 16,
  parameter int LANE_W = 4
) (
  input  logic [CNT_W-1:0]  a,
  input  logic [LANE_W-1:0] b,
  output logic [CNT_W-1:0]  sum,
  output logic              ovf
);

  logic [CNT_W:0] full_sum;

  // Add one bit wider than the count; if the carry is set, pin the sum at all-ones.
  always_comb begin
    full_sum = {1'b0, a} + (CNT_W + 1)'(b);
    ovf      = full_sum[CNT_W];
    sum      = ovf ? '1 : full_sum[CNT_W-1:0];
  end

endmodule

// File: rtl/tx_frame_byte_counter.sv
// Per-frame TX byte counter. Accumulates a variable number of bytes per beat,
// saturates rather than wrapping, and at end of frame latches the length
// together with the pad, undersize and oversize information.
//
// Beat handshake: a beat is taken on every rising edge where VALID=1. There is
// no back-pressure. SOF, EOF and BYTES are ignored when VALID=0. ABORT acts
// whether VALID is high or low, and it discards any beat in the same cycle.
module tx_frame_byte_counter
  import tx_cnt_pkg::*;
#(
  parameter  int CNT_W   = 16,
  parameter  int LANES   = 8,
  parameter  int MIN_LEN = ETH_MIN_LEN,
  parameter  int MAX_LEN = ETH_MAX_LEN,
  localparam int LANE_W  = $clog2(LANES + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              VALID,
  input  logic              SOF,
  input  logic              EOF,
  input  logic [LANE_W-1:0] BYTES,
  input  logic              ABORT,
  output logic [CNT_W-1:0]  BYTE_COUNTER,
  output logic [CNT_W-1:0]  FRAME_LEN,
  output logic [CNT_W-1:0]  PAD_BYTES,
  output logic              LEN_VALID,
  output logic              UNDERSIZE,
  output logic              OVERSIZE,
  output logic              SATURATED,
  output logic              PROTO_ERR
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [CNT_W-1:0]   frame_len_q, frame_len_d;
  logic [CNT_W-1:0]   pad_q, pad_d;
  logic               len_valid_q, len_valid_d;
  logic               under_q, under_d;
  logic               over_q, over_d;
  logic               proto_err_q, proto_err_d;

  logic [LANE_W-1:0]  eff;
  logic [CNT_W-1:0]   add_sum;
  logic               add_ovf;
  logic               do_latch;
  logic [CNT_W-1:0]   latch_len;
  logic               latch_sat;

  // Bytes this beat actually contributes, limited to the datapath width.
  always_comb begin
    eff = LANE_W'(clamp_bytes(32'(BYTES), 32'(LANES)));
  end

  sat_add #(
    .CNT_W  (CNT_W),
    .LANE_W (LANE_W)
  ) u_sat_add (
    .a   (cnt_q),
    .b   (eff),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Next-state logic: framing FSM, running count, and the end-of-frame latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    frame_len_d = frame_len_q;
    pad_d       = pad_q;
    under_d     = under_q;
    over_d      = over_q;
    len_valid_d = 1'b0;
    proto_err_d = 1'b0;
    do_latch    = 1'b0;
    latch_len   = '0;
    latch_sat   = 1'b0;

    if (ABORT) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (VALID) begin
      if (SOF) begin
        // A SOF received inside a frame drops the old frame and starts a new one.
        proto_err_d = (state_q == ST_COUNT);
        cnt_d       = CNT_W'(eff);
        sat_d       = 1'b0;
        if (EOF) begin
          do_latch  = 1'b1;
          latch_len = CNT_W'(eff);
          state_d   = ST_IDLE;
        end else begin
          state_d   = ST_COUNT;
        end
      end else if (state_q == ST_IDLE) begin
        // Data received outside a frame is dropped.
        proto_err_d = 1'b1;
      end else begin
        cnt_d = add_sum;
        sat_d = sat_q | add_ovf;
        if (EOF) begin
          do_latch  = 1'b1;
          latch_len = add_sum;
          latch_sat = sat_q | add_ovf;
          state_d   = ST_IDLE;
        end
      end
    end

    if (do_latch) begin
      len_valid_d = 1'b1;
      frame_len_d = latch_len;
      under_d     = (int'(latch_len) < MIN_LEN);
      pad_d       = under_d ? CNT_W'(MIN_LEN - int'(latch_len)) : '0;
      over_d      = latch_sat || (int'(latch_len) > MAX_LEN);
    end
  end

  // State and output registers. The reset is synchronous and clears everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      frame_len_q <= '0;
      pad_q       <= '0;
      len_valid_q <= 1'b0;
      under_q     <= 1'b0;
      over_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      frame_len_q <= frame_len_d;
      pad_q       <= pad_d;
      len_valid_q <= len_valid_d;
      under_q     <= under_d;
      over_q      <= over_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign BYTE_COUNTER = cnt_q;
  assign FRAME_LEN    = frame_len_q;
  assign PAD_BYTES    = pad_q;
  assign LEN_VALID    = len_valid_q;
  assign UNDERSIZE    = under_q;
  assign OVERSIZE     = over_q;
  assign SATURATED    = sat_q;
  assign PROTO_ERR    = proto_err_q;

endmodule

// File: tb/tb_tx_frame_byte_counter.sv
// Bench for tx_frame_byte_counter. It runs a 16-bit and an 8-bit instance side
// by side on the same stimulus and compares both against a frame-level model.
module tb_tx_frame_byte_counter;

  localparam int LANES = 8;
  localparam int MIN_L = 60;
  localparam int MAX_L = 1514;

  // ---------------- clock / reset / inputs ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid = 1'b0, sof = 1'b0, eof = 1'b0, abort = 1'b0;
  logic [3:0] bytes = '0;

  always #5 clk = ~clk;

  logic [15:0] cnt16, fl16, pad16;
  logic        lv16, un16, ov16, sat16, pe16;
  logic [7:0]  cnt8, fl8, pad8;
  logic        lv8, un8, ov8, sat8, pe8;

  tx_frame_byte_counter #(.CNT_W(16)) dut16 (
    .CLK(clk), .RESET(reset), .VALID(valid), .SOF(sof), .EOF(eof),
    .BYTES(bytes), .ABORT(abort),
    .BYTE_COUNTER(cnt16), .FRAME_LEN(fl16), .PAD_BYTES(pad16),
    .LEN_VALID(lv16), .UNDERSIZE(un16), .OVERSIZE(ov16),
    .SATURATED(sat16), .PROTO_ERR(pe16)
  );

  tx_frame_byte_counter #(.CNT_W(8)) dut8 (
    .CLK(clk), .RESET(reset), .VALID(valid), .SOF(sof), .EOF(eof),
    .BYTES(bytes), .ABORT(abort),
    .BYTE_COUNTER(cnt8), .FRAME_LEN(fl8), .PAD_BYTES(pad8),
    .LEN_VALID(lv8), .UNDERSIZE(un8), .OVERSIZE(ov8),
    .SATURATED(sat8), .PROTO_ERR(pe8)
  );

  // ---------------- reference model ----------------
  // The model keeps the true, unbounded byte sum of the current frame. The
  // counter the DUT shows is min(sum, 2^W-1), and the DUT is saturated
  // exactly when sum > 2^W-1.
  int m_max [2] = '{65535, 255};
  int m_sum [2];
  bit m_in  [2];
  int m_fl  [2];
  int m_pad [2];
  bit m_lv  [2];
  bit m_un  [2];
  bit m_ov  [2];
  bit m_pe  [2];

  logic [15:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int shown(input int i);
    return (m_sum[i] > m_max[i]) ? m_max[i] : m_sum[i];
  endfunction

  task automatic model_latch(input int i);
    int l;
    l = shown(i);
    m_lv[i]  = 1'b1;
    m_fl[i]  = l;
    m_un[i]  = (l < MIN_L);
    m_pad[i] = (l < MIN_L) ? (MIN_L - l) : 0;
    m_ov[i]  = (l > MAX_L) || (m_sum[i] > m_max[i]);
    m_in[i]  = 1'b0;
    if (i == 0) exp_q.push_back(16'(l));
  endtask

  task automatic model_step(input int i);
    int e;
    e = (int'(bytes) > LANES) ? LANES : int'(bytes);
    m_lv[i] = 1'b0;
    m_pe[i] = 1'b0;
    if (reset) begin
      m_sum[i] = 0; m_in[i] = 1'b0; m_fl[i] = 0; m_pad[i] = 0;
      m_un[i] = 1'b0; m_ov[i] = 1'b0;
    end else if (abort) begin
      m_sum[i] = 0; m_in[i] = 1'b0;
    end else if (valid) begin
      if (sof) begin
        m_pe[i]  = m_in[i];
        m_sum[i] = e;
        m_in[i]  = 1'b1;
        if (eof) model_latch(i);
      end else if (!m_in[i]) begin
        m_pe[i] = 1'b1;
      end else begin
        m_sum[i] = m_sum[i] + e;
        if (eof) model_latch(i);
      end
    end
  endtask

  task automatic compare_all();
    check("d16.byte_counter", 32'(cnt16), 32'(shown(0)));
    check("d16.saturated",    32'(sat16), 32'(m_sum[0] > m_max[0]));
    check("d16.frame_len",    32'(fl16),  32'(m_fl[0]));
    check("d16.pad_bytes",    32'(pad16), 32'(m_pad[0]));
    check("d16.len_valid",    32'(lv16),  32'(m_lv[0]));
    check("d16.undersize",    32'(un16),  32'(m_un[0]));
    check("d16.oversize",     32'(ov16),  32'(m_ov[0]));
    check("d16.proto_err",    32'(pe16),  32'(m_pe[0]));
    check("d8.byte_counter",  32'(cnt8),  32'(shown(1)));
    check("d8.saturated",     32'(sat8),  32'(m_sum[1] > m_max[1]));
    check("d8.frame_len",     32'(fl8),   32'(m_fl[1]));
    check("d8.pad_bytes",     32'(pad8),  32'(m_pad[1]));
    check("d8.len_valid",     32'(lv8),   32'(m_lv[1]));
    check("d8.undersize",     32'(un8),   32'(m_un[1]));
    check("d8.oversize",      32'(ov8),   32'(m_ov[1]));
    check("d8.proto_err",     32'(pe8),   32'(m_pe[1]));
    // Each length the DUT reports must match the oldest frame the model completed.
    if (lv16 === 1'b1) begin
      if (exp_q.size() > 0) check("sb.frame_len", 32'(fl16), 32'(exp_q.pop_front()));
      else                  check("sb.unexpected_len_valid", 32'(1), 32'(0));
    end
  endtask

  // ---------------- driver ----------------
  task automatic beat(input bit v, input bit s, input bit e, input int b,
                      input bit a = 1'b0, input bit r = 1'b0);
    @(negedge clk);
    valid = v; sof = s; eof = e; bytes = 4'(b); abort = a; reset = r;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, 1'b0, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_sum[i] = 0; m_in[i] = 1'b0; m_fl[i] = 0; m_pad[i] = 0;
      m_lv[i] = 1'b0; m_un[i] = 1'b0; m_ov[i] = 1'b0; m_pe[i] = 1'b0;
    end

    // After reset every output is zero.
    beat(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    beat(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    check("reset.byte_counter", 32'(cnt16), 32'(0));
    check("reset.frame_len",    32'(fl16),  32'(0));
    idle();

    // A 68-byte frame: eight beats of 8 bytes, then an EOF beat of 4 bytes.
    beat(1'b1, 1'b1, 1'b0, 8);
    for (int k = 0; k < 7; k++) beat(1'b1, 1'b0, 1'b0, 8);
    check("f68.running", 32'(cnt16), 32'(64));
    beat(1'b1, 1'b0, 1'b1, 4);
    check("f68.len_valid", 32'(lv16),  32'(1));
    check("f68.frame_len", 32'(fl16),  32'(68));
    check("f68.pad",       32'(pad16), 32'(0));
    check("f68.undersize", 32'(un16),  32'(0));
    idle();
    check("f68.pulse_one_cycle", 32'(lv16), 32'(0));
    check("f68.len_held",        32'(fl16), 32'(68));

    // A single-beat frame of 5 bytes.
    beat(1'b1, 1'b1, 1'b1, 5);
    check("single.frame_len", 32'(fl16),  32'(5));
    check("single.pad",       32'(pad16), 32'(55));
    check("single.undersize", 32'(un16),  32'(1));
    beat(1'b1, 1'b0, 1'b0, 3);  // data outside a frame: the DUT must still be idle
    check("single.still_idle_proto", 32'(pe16), 32'(1));
    idle();

    // Drive the 8-bit instance into saturation.
    beat(1'b1, 1'b1, 1'b0, 8);
    for (int k = 0; k < 39; k++) beat(1'b1, 1'b0, 1'b0, 8);
    check("sat.pinned",    32'(cnt8), 32'(255));
    check("sat.flag",      32'(sat8), 32'(1));
    beat(1'b1, 1'b0, 1'b1, 8);
    check("sat.oversize",  32'(ov8),  32'(1));
    check("sat.frame_len", 32'(fl8),  32'(255));
    idle();

    // Abort in the middle of a frame, then start a new frame.
    beat(1'b1, 1'b1, 1'b0, 8);
    beat(1'b1, 1'b0, 1'b0, 8);
    beat(1'b1, 1'b0, 1'b0, 8);
    beat(1'b1, 1'b0, 1'b1, 8, 1'b1);
    check("abort.count",     32'(cnt16), 32'(0));
    check("abort.len_valid", 32'(lv16),  32'(0));
    beat(1'b1, 1'b1, 1'b0, 3);
    check("abort.new_sof", 32'(cnt16), 32'(3));
    beat(1'b1, 1'b0, 1'b1, 4);
    idle();

    // A SOF inside a frame, then data received while idle.
    beat(1'b1, 1'b1, 1'b0, 8);
    beat(1'b1, 1'b0, 1'b0, 8);
    beat(1'b1, 1'b1, 1'b0, 2);
    check("nested.proto_err", 32'(pe16), 32'(1));
    check("nested.count",     32'(cnt16), 32'(2));
    check("nested.no_len",    32'(lv16), 32'(0));
    beat(1'b1, 1'b0, 1'b1, 0);
    check("nested.len", 32'(fl16), 32'(2));
    beat(1'b1, 1'b0, 1'b0, 7);
    check("idle_data.proto_err", 32'(pe16),  32'(1));
    check("idle_data.count",     32'(cnt16), 32'(2));

    // A BYTES value above LANES is clamped. VALID=0 changes nothing. Reset mid-frame.
    beat(1'b1, 1'b1, 1'b0, 15);
    check("clamp.count", 32'(cnt16), 32'(8));
    beat(1'b0, 1'b1, 1'b1, 5);
    check("novalid.count", 32'(cnt16), 32'(8));
    beat(1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b1);
    check("reset_mid.count",     32'(cnt16), 32'(0));
    check("reset_mid.frame_len", 32'(fl16),  32'(0));
    check("reset_mid.under",     32'(un16),  32'(0));

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      beat($urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 8,
           int'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 199) < 1);
    end
    idle();
    idle();

    check("sb.outstanding", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
